// File: rtl/ahb_lite_arbiter_pkg.sv
// Shared constants and FSM state type for the two-requester AHB-Lite arbiter.
// Only NONSEQ single-word transfers are ever issued.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/ahb_lite_arbiter_if.sv
// Bundles both requester handshakes and the AHB-Lite master signals.
// The arbiter uses the master modport; requesters and slave fabric use slave.
interface ahb_lite_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY
  );

endinterface

// File: rtl/ahb_lite_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin grant: on a tie the requester that was
// not granted last wins. Grant is one-hot and only asserted when enabled.
module rr_arbiter_2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      if (i_valid0 && (!i_valid1 || i_last_grant)) begin
        o_grant = 2'b01;
      end else if (i_valid1) begin
        o_grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Shares one AHB-Lite master port between two single-word requesters,
// running non-overlapping address and data phases with HREADY wait states.
module ahb_lite_arbiter
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_lite_arbiter_if.master bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_slot;
  logic              w_complete;
  logic              w_accept;
  logic [1:0]        w_grant;

  // Gating with HRESETn keeps ready low while reset is held, since ready is combinational.
  assign w_slot     = HRESETn && ((r_state == ST_IDLE) || ((r_state == ST_DATA) && bus.HREADY));
  assign w_complete = (r_state == ST_DATA) && bus.HREADY;
  assign w_accept   = |w_grant;

  rr_arbiter_2 u_rr_arbiter (
    .i_valid0     (bus.req0_valid),
    .i_valid1     (bus.req1_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_slot),
    .o_grant      (w_grant)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_ADDR;
      ST_ADDR: if (bus.HREADY) w_next_state = ST_DATA;
      ST_DATA: if (bus.HREADY) w_next_state = w_accept ? ST_ADDR : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture registers change only on acceptance, so HADDR/HWRITE hold between transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant[1];
      r_owner      <= w_grant[1];
      r_write      <= w_grant[1] ? bus.req1_write : bus.req0_write;
      r_addr       <= w_grant[1] ? bus.req1_addr  : bus.req0_addr;
      r_wdata      <= w_grant[1] ? bus.req1_wdata : bus.req0_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_done0 <= w_complete && !r_owner;
      r_done1 <= w_complete && r_owner;
      if (w_complete && !r_write) begin
        if (r_owner) r_rdata1 <= bus.HRDATA;
        else         r_rdata0 <= bus.HRDATA;
      end
    end
  end

  assign bus.HTRANS = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR  = r_addr;
  assign bus.HWRITE = r_write;
  assign bus.HWDATA = ((r_state == ST_DATA) && r_write) ? r_wdata : '0;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_SINGLE;

  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.req0_done  = r_done0;
  assign bus.req1_done  = r_done1;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_rdata = r_rdata1;

endmodule

// File: doc/ahb_lite_arbiter.md
# ahb_lite_arbiter

Shares one AHB-Lite master port between two simple requesters, such as a CPU-side command port and the SPI bridge's DMA/refill engine. Each requester issues single-word read or write commands over a valid/ready handshake. The arbiter picks one requester round-robin, drives the AHB-Lite address and data phases while honouring HREADY wait states, and returns read data with a one-cycle done pulse. It sits between the requesters and the AHB-Lite slave fabric, in place of a single hard-wired master.

## Interface
- ADDR_W, 8, HADDR / request address width
- DATA_W, 32, HWDATA / HRDATA / request data width
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- reqN_valid  in  1  requester N (N=0,1) has a command
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  DATA_W  write data
- reqN_ready  out  1  command accepted this cycle (combinational)
- reqN_done  out  1  one-cycle pulse: transfer complete
- reqN_rdata  out  DATA_W  read data; valid when reqN_done=1, held until next read by N
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  IDLE=00, NONSEQ=10 only
- HWRITE  out  1  transfer direction
- HSIZE  out  3  constant 010 (word)
- HBURST  out  3  constant 000 (SINGLE)
- HWDATA  out  DATA_W  write data in data phase
- HRDATA  in  DATA_W  read data from slave
- HREADY  in  1  slave ready / phase complete

## Operation
- FSM states are IDLE, ADDR and DATA.
- Accept slot: state==IDLE, or state==DATA with HREADY=1. In a slot with any valid, exactly one reqN_ready=1. The command is captured at that edge, and the next state is ADDR.
- Arbitration: if only one requester is valid, it wins. If both are valid, the one not granted last wins. The last-grant pointer resets so req0 wins the first tie. The pointer updates only on acceptance.
- ADDR: HTRANS=NONSEQ, and HADDR/HWRITE come from the capture registers. Stay in ADDR while HREADY=0. Go to DATA on HREADY=1.
- DATA: HTRANS=IDLE. HWDATA = captured wdata for writes, and 0 for reads. Stay while HREADY=0. On the HREADY=1 edge:
  - latch HRDATA into the owner's rdata for reads (rdata unchanged for writes);
  - register the owner's done pulse;
  - go to ADDR if a new command is accepted in the same slot, else IDLE.
- HADDR and HWRITE hold their value outside ADDR. Address and data phases of different transfers never overlap.
- No HRESP handling. Every transfer is assumed OKAY.
- A requester that still holds valid after its ready/done is treated as issuing a new command.

## Timing
- Reset values:
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, HSIZE=010, HBURST=000;
  - reqN_ready=0, reqN_done=0, reqN_rdata=0;
  - state IDLE; pointer = "1 granted last".
- Zero-wait latency:
  - accept at edge E0;
  - ADDR during E0–E1;
  - DATA during E1–E2;
  - done=1 and rdata valid in the cycle after E2.
- Throughput: one transfer per 2 cycles at zero wait states.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle. All bus outputs stay stable while stalled.
- reqN_ready is never asserted outside an accept slot.
- Simultaneous events: done for transfer K and ready for transfer K+1 may share a cycle, for the same or different requesters.
- Reset mid-transfer: outputs return to reset values immediately (async). The in-flight command is dropped and no done is issued.
- valid deasserted before ready: no transfer and no pointer change.

## Structure
- Package ahb_lite_pkg holds:
  - constants HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE;
  - the FSM state enum.
- Sub-module rr_arbiter_2 is combinational. Inputs: two valids, last-grant bit, enable. Outputs: one-hot grant. The top level owns the pointer register.

## Test plan
- Reset asserted with req0_valid=1 → HTRANS=00, no ready. After release, req0 is accepted at the first edge.
- req0 write addr 0x10 data 0xDEADBEEF, HREADY=1 → NONSEQ with HADDR=0x10, HWRITE=1 for one cycle. Next cycle HWDATA=0xDEADBEEF. req0_done one cycle later.
- req1 read addr 0x24, slave returns {24'h0,HADDR}, HREADY low for 2 DATA cycles → HWDATA/HADDR stable through the stall. req1_rdata=0x00000024 with req1_done, 2 cycles later than zero-wait.
- req0 and req1 continuously valid → grants alternate 0,1,0,1, starting with 0. One transfer per 2 cycles. done and the next ready coincide.
- HRESETn pulsed low during DATA of a read → no done, HTRANS=00. After release, the pending requester is accepted fresh.
- HREADY=0 during ADDR for 3 cycles → NONSEQ held 4 cycles total with a constant address. DATA follows.
